// File: rtl/game_round_sequencer.sv
// Round-level FSM for the catch-the-light game: countdown, timed play, game-over hold,
// round clearing and BCD high-score tracking. All outputs are registered.
module game_round_sequencer #(
    parameter int unsigned COUNTDOWN_SECS = 3,
    parameter int unsigned OVER_HOLD_SECS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_clk,
    input  logic       start,
    input  logic       abort,
    input  logic       time_up,
    input  logic [3:0] score_ones,
    input  logic [3:0] score_tens,
    output logic [1:0] state,
    output logic       game_run,
    output logic       round_clear,
    output logic [3:0] count_digit,
    output logic [3:0] high_ones,
    output logic [3:0] high_tens,
    output logic       new_record,
    output logic       led_blink
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_PLAY      = 2'd2,
        S_OVER      = 2'd3
    } state_t;

    localparam logic [3:0] CD_INIT  = 4'(COUNTDOWN_SECS);
    localparam logic [3:0] HOLD_MAX = 4'(OVER_HOLD_SECS);

    state_t     state_q, state_d;
    logic       sec_q, start_q;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] high_q, high_d;
    logic [3:0] digit_q, digit_d;
    logic       rc_q, rc_d;
    logic       run_q, run_d;
    logic       rec_q, rec_d;
    logic       led_q, led_d;

    logic       sec_edge, start_edge;
    logic [7:0] score;

    assign sec_edge   = sec_clk & ~sec_q;
    assign start_edge = start & ~start_q;
    assign score      = {score_tens, score_ones};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sec_q   <= 1'b1;
            start_q <= 1'b1;
            cnt_q   <= '0;
            hold_q  <= '0;
            high_q  <= '0;
            digit_q <= '0;
            rc_q    <= 1'b0;
            run_q   <= 1'b0;
            rec_q   <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_clk;
            start_q <= start;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            high_q  <= high_d;
            digit_q <= digit_d;
            rc_q    <= rc_d;
            run_q   <= run_d;
            rec_q   <= rec_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        high_d  = high_q;
        digit_d = digit_q;
        rc_d    = 1'b0;
        run_d   = run_q;
        rec_d   = rec_q;
        led_d   = led_q;

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hold_d  = '0;
            digit_d = '0;
            run_d   = 1'b0;
            rec_d   = 1'b0;
            led_d   = 1'b0;
        end else if (start_edge && state_q != S_PLAY) begin
            // Any non-PLAY state restarts a fresh countdown with a clear pulse.
            state_d = S_COUNTDOWN;
            cnt_d   = CD_INIT;
            digit_d = CD_INIT;
            hold_d  = '0;
            rc_d    = 1'b1;
            run_d   = 1'b0;
            rec_d   = 1'b0;
            led_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_COUNTDOWN: begin
                    if (sec_edge) begin
                        if (cnt_q == 4'd1) begin
                            state_d = S_PLAY;
                            cnt_d   = '0;
                            digit_d = '0;
                            run_d   = 1'b1;
                        end else begin
                            cnt_d   = cnt_q - 4'd1;
                            digit_d = cnt_q - 4'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (time_up) begin
                        state_d = S_OVER;
                        run_d   = 1'b0;
                        // Packed BCD with valid digits orders the same as binary.
                        if (score > high_q) begin
                            high_d = score;
                            rec_d  = 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    if (sec_edge) begin
                        if (hold_q + 4'd1 == HOLD_MAX) begin
                            state_d = S_IDLE;
                            hold_d  = '0;
                            led_d   = 1'b0;
                            rec_d   = 1'b0;
                        end else begin
                            hold_d = hold_q + 4'd1;
                            led_d  = ~led_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign game_run    = run_q;
    assign round_clear = rc_q;
    assign count_digit = digit_q;
    assign high_ones   = high_q[3:0];
    assign high_tens   = high_q[7:4];
    assign new_record  = rec_q;
    assign led_blink   = led_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer: directed scenarios plus a randomized phase, all
// compared every cycle against a decimal-integer reference model of the game rules.
module tb_game_round_sequencer;

    localparam int CD   = 3;
    localparam int HOLD = 5;

    logic       clk = 1'b0;
    logic       reset, sec_clk, start, abort, time_up;
    logic [3:0] score_ones, score_tens;
    logic [1:0] state;
    logic       game_run, round_clear, new_record, led_blink;
    logic [3:0] count_digit, high_ones, high_tens;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers, high score held as a decimal number 0..99.
    int m_state, m_cnt, m_hold, m_high, m_digit;
    bit m_rc, m_run, m_rec, m_led, m_prev_sec, m_prev_start;

    game_round_sequencer #(.COUNTDOWN_SECS(CD), .OVER_HOLD_SECS(HOLD)) dut (
        .clk(clk), .reset(reset), .sec_clk(sec_clk), .start(start), .abort(abort),
        .time_up(time_up), .score_ones(score_ones), .score_tens(score_tens),
        .state(state), .game_run(game_run), .round_clear(round_clear),
        .count_digit(count_digit), .high_ones(high_ones), .high_tens(high_tens),
        .new_record(new_record), .led_blink(led_blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("state",       32'(state),       32'(m_state));
        chk("game_run",    32'(game_run),    32'(m_run));
        chk("round_clear", 32'(round_clear), 32'(m_rc));
        chk("count_digit", 32'(count_digit), 32'(m_digit));
        chk("high_tens",   32'(high_tens),   32'(m_high / 10));
        chk("high_ones",   32'(high_ones),   32'(m_high % 10));
        chk("new_record",  32'(new_record),  32'(m_rec));
        chk("led_blink",   32'(led_blink),   32'(m_led));
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_hold = 0; m_high = 0; m_digit = 0;
        m_rc = 0; m_run = 0; m_rec = 0; m_led = 0;
        m_prev_sec = 1; m_prev_start = 1;
    endtask

    task automatic model_step();
        bit se, st;
        int sc;
        se = sec_clk && !m_prev_sec;
        st = start && !m_prev_start;
        m_prev_sec = sec_clk;
        m_prev_start = start;
        sc = int'(score_tens) * 10 + int'(score_ones);
        m_rc = 0;
        if (abort) begin
            m_state = 0; m_run = 0; m_digit = 0; m_rec = 0; m_led = 0; m_cnt = 0; m_hold = 0;
        end else if (st && m_state != 2) begin
            m_state = 1; m_cnt = CD; m_digit = CD; m_rc = 1;
            m_rec = 0; m_led = 0; m_hold = 0; m_run = 0;
        end else if (m_state == 1 && se) begin
            if (m_cnt == 1) begin
                m_state = 2; m_digit = 0; m_run = 1; m_cnt = 0;
            end else begin
                m_cnt--; m_digit = m_cnt;
            end
        end else if (m_state == 2 && time_up) begin
            m_state = 3; m_run = 0;
            if (sc > m_high) begin
                m_high = sc; m_rec = 1;
            end
        end else if (m_state == 3 && se) begin
            m_hold++;
            m_led = !m_led;
            if (m_hold == HOLD) begin
                m_state = 0; m_led = 0; m_rec = 0; m_hold = 0;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic sec_pulse();
        sec_clk = 1'b1; cycle();
        sec_clk = 1'b0; cycle();
    endtask

    task automatic start_pulse();
        start = 1'b1; cycle();
        start = 1'b0; cycle();
    endtask

    task automatic play_round(input int tens, input int ones);
        start_pulse();
        for (int i = 0; i < CD; i++) sec_pulse();
        score_tens = 4'(tens); score_ones = 4'(ones);
        time_up = 1'b1; cycle();
        time_up = 1'b0; cycle();
    endtask

    initial begin
        reset = 1'b1; sec_clk = 1'b0; start = 1'b0; abort = 1'b0; time_up = 1'b0;
        score_ones = '0; score_tens = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all();
        reset = 1'b0;
        cycle();

        // Round 1: score 27 beats 00, then full OVER hold back to IDLE.
        play_round(2, 7);
        for (int i = 0; i < HOLD; i++) sec_pulse();

        // Round 2: equal score, no record; start edge coincident with hold expiry.
        play_round(2, 7);
        for (int i = 0; i < HOLD - 1; i++) sec_pulse();
        sec_clk = 1'b1; start = 1'b1; cycle();
        sec_clk = 1'b0; start = 1'b0; cycle();
        for (int i = 0; i < CD; i++) sec_pulse();
        score_tens = 4'd3; score_ones = 4'd1;
        time_up = 1'b1; cycle();
        time_up = 1'b0; cycle();

        // Abort together with a start edge in COUNTDOWN, then in PLAY.
        start_pulse();
        sec_pulse();
        abort = 1'b1; start = 1'b1; cycle();
        abort = 1'b0; start = 1'b0; cycle();
        start_pulse();
        for (int i = 0; i < CD; i++) sec_pulse();
        abort = 1'b1; start = 1'b1; cycle();
        abort = 1'b0; start = 1'b0; cycle();

        // Levels already high at reset release must not count as edges.
        reset = 1'b1; start = 1'b1; sec_clk = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check_all();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        sec_clk = 1'b0; cycle();
        start = 1'b0; cycle();
        start_pulse();

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) sec_clk = ~sec_clk;
            if ($urandom_range(0, 5) == 0) start = ~start;
            abort   = ($urandom_range(0, 40) == 0);
            time_up = ($urandom_range(0, 7) == 0);
            score_tens = 4'($urandom_range(0, 9));
            score_ones = 4'($urandom_range(0, 9));
            cycle();
        end

        // Asynchronous reset in the middle of PLAY.
        abort = 1'b1; start = 1'b0; sec_clk = 1'b0; time_up = 1'b0; cycle();
        abort = 1'b0; cycle();
        play_round(5, 5);
        for (int i = 0; i < HOLD; i++) sec_pulse();
        start_pulse();
        for (int i = 0; i < CD; i++) sec_pulse();
        cycle();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;
        cycle();
        start_pulse();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
